iir_lp_mc: RTL and testbench

Parametrised, multi-channel, time-multiplexed first-order IIR low-pass filter: y[m] = y[m-1] + 2^-K·(x[m] - y[m-1]) per channel.
- Implemented as a leaky integrator with K fractional guard bits.
- Adds per-channel state, per-channel clear, a bypass mode and output saturation.
- Sits after the sample demux in the filter demo chain and feeds the display/DAC path.

---
 rtl/iir_lp_mc.sv | 128 ++++++++++++
 tb/tb_iir_lp_mc.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/iir_lp_mc.sv
// iir_lp_mc: multi-channel, time-multiplexed first-order IIR low-pass filter.
//   y[m] = y[m-1] + 2^-K * (x[m] - y[m-1]) per channel, built as a leaky
//   integrator acc ~= y * 2^K with K fractional guard bits.
//   Two-stage pipeline: stage 1 updates the channel accumulator, stage 2
//   rounds (half up), saturates and registers the output.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ch/in_x sample strobe, channel, signed sample (no back-pressure)
//   bypass              1 = output equals input; state tracks the input
//   clr/clr_ch          clear request for one channel's accumulator
//   out_valid/out_ch/out_y  output strobe, channel, signed filtered sample
module iir_lp_mc #(
  parameter int unsigned DW = 8,
  parameter int unsigned K  = 7,
  parameter int unsigned CH = 4,
  parameter int unsigned CW = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [CW-1:0]        in_ch,
  input  logic signed [DW-1:0] in_x,
  input  logic                 bypass,
  input  logic                 clr,
  input  logic [CW-1:0]        clr_ch,
  output logic                 out_valid,
  output logic [CW-1:0]        out_ch,
  output logic signed [DW-1:0] out_y
);

  localparam int unsigned AW = DW + K + 1;
  localparam logic [CW:0]         CH_L = (CW+1)'(CH);
  localparam logic signed [AW:0]  RND  = (AW+1)'(2**(K-1));
  localparam logic signed [AW:0]  YMAX = (AW+1)'(2**(DW-1) - 1);
  localparam logic signed [AW:0]  YMIN = (AW+1)'(-(2**(DW-1)));

  logic signed [AW-1:0] r_acc [CH];

  logic                 r_s1_valid;
  logic signed [AW-1:0] r_s1_acc;
  logic [CW-1:0]        r_s1_ch;
  logic                 r_s1_byp;

  logic                 r_out_valid;
  logic [CW-1:0]        r_out_ch;
  logic signed [DW-1:0] r_out_y;

  logic                 w_in_ok;
  logic                 w_clr_ok;
  logic signed [AW-1:0] w_sx;
  logic signed [AW-1:0] w_a;
  logic signed [AW-1:0] w_acc_new;
  logic signed [AW:0]   w_s1_ext;
  logic signed [AW:0]   w_r;
  logic signed [DW-1:0] w_y;

  // Stage 1: channel accumulator update; a same-channel clear zeroes the operand first
  always_comb begin
    w_in_ok   = in_valid && ({1'b0, in_ch} < CH_L);
    w_clr_ok  = clr && ({1'b0, clr_ch} < CH_L);
    w_sx      = {{(AW-DW){in_x[DW-1]}}, in_x};
    w_a       = '0;
    if (w_in_ok && !(clr && (clr_ch == in_ch))) begin
      w_a = r_acc[in_ch];
    end
    if (bypass) begin
      w_acc_new = w_sx << K;
    end else begin
      // floor leak: a negative steady state settles one LSB high
      w_acc_new = w_a - (w_a >>> K) + w_sx;
    end
  end

  // Stage 2: round half up, then saturate (guard only; legal inputs stay in range)
  always_comb begin
    w_s1_ext = $signed({r_s1_acc[AW-1], r_s1_acc});
    if (r_s1_byp) begin
      w_r = w_s1_ext >>> K;
    end else begin
      w_r = (w_s1_ext + RND) >>> K;
    end
    if (w_r > YMAX) begin
      w_y = DW'(YMAX);
    end else if (w_r < YMIN) begin
      w_y = DW'(YMIN);
    end else begin
      w_y = DW'(w_r);
    end
  end

  // State, pipeline and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < int'(CH); c++) begin
        r_acc[c] <= '0;
      end
      r_s1_valid  <= 1'b0;
      r_s1_acc    <= '0;
      r_s1_ch     <= '0;
      r_s1_byp    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_ch    <= '0;
      r_out_y     <= '0;
    end else begin
      if (w_clr_ok) begin
        r_acc[clr_ch] <= '0;
      end
      // sample write comes last so it wins over a same-channel clear
      if (w_in_ok) begin
        r_acc[in_ch] <= w_acc_new;
        r_s1_acc     <= w_acc_new;
        r_s1_ch      <= in_ch;
        r_s1_byp     <= bypass;
      end
      r_s1_valid  <= w_in_ok;
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_ch <= r_s1_ch;
        r_out_y  <= w_y;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_ch    = r_out_ch;
  assign out_y     = r_out_y;

endmodule

// File: tb/tb_iir_lp_mc.sv
// Bench for iir_lp_mc: hand-computed vector table, model-driven scoreboard
// for long trajectories, and directed clear/bypass/reset/out-of-range cases.
module tb_iir_lp_mc;
  localparam int DW = 8;
  localparam int K  = 7;
  localparam int CH = 4;
  localparam int CW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic                 in_valid, bypass, clr;
  logic [CW-1:0]        in_ch, clr_ch;
  logic signed [DW-1:0] in_x;
  logic                 out_valid;
  logic [CW-1:0]        out_ch;
  logic signed [DW-1:0] out_y;

  logic                 d3_in_valid, d3_bypass, d3_clr;
  logic [2:0]           d3_in_ch, d3_clr_ch, d3_out_ch;
  logic signed [DW-1:0] d3_in_x, d3_out_y;
  logic                 d3_out_valid;

  iir_lp_mc #(.DW(DW), .K(K), .CH(CH), .CW(CW)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ch(in_ch), .in_x(in_x),
    .bypass(bypass), .clr(clr), .clr_ch(clr_ch),
    .out_valid(out_valid), .out_ch(out_ch), .out_y(out_y));

  iir_lp_mc #(.DW(DW), .K(K), .CH(CH), .CW(3)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(d3_in_valid), .in_ch(d3_in_ch), .in_x(d3_in_x),
    .bypass(d3_bypass), .clr(d3_clr), .clr_ch(d3_clr_ch),
    .out_valid(d3_out_valid), .out_ch(d3_out_ch), .out_y(d3_out_y));

  typedef struct {
    int ch; int x; bit byp; bit cl; int cch; int exp_y;
  } vec_t;
  typedef struct { int ch; int y; int cyc; } exp_t;

  exp_t sb[$];
  int   d3_ys[$];
  int   model [CH];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  vec_t tbl [12];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int m_out(input int acc);
    int r;
    r = (acc + (1 << (K-1))) >>> K;
    if (r > (1 << (DW-1)) - 1) r = (1 << (DW-1)) - 1;
    if (r < -(1 << (DW-1)))    r = -(1 << (DW-1));
    return r;
  endfunction

  // Scoreboard monitor: every output strobe must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_out: ch=%0d y=%0d with nothing expected", out_ch, out_y);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (int'(out_ch) != e.ch || int'(out_y) != e.y || cyc != e.cyc + 2) begin
          n_fail++;
          $display("FAIL out_sample: got ch=%0d y=%0d cyc=%0d, want ch=%0d y=%0d cyc=%0d",
                   out_ch, out_y, cyc, e.ch, e.y, e.cyc + 2);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && d3_out_valid) d3_ys.push_back(int'(d3_out_y));
  end

  task automatic model_clear();
    for (int c = 0; c < CH; c++) model[c] = 0;
  endtask

  // Drive one sample for one cycle; model update and expectation push
  task automatic step(input int ch, input int x, input bit byp, input bit cl,
                      input int cch, input bit use_c, input int c_y);
    exp_t e;
    int   a;
    in_valid = 1'b1; in_ch = CW'(ch); in_x = DW'(x); bypass = byp;
    clr = cl; clr_ch = CW'(cch);
    if (cl && cch < CH) model[cch] = 0;
    a = model[ch];
    model[ch] = byp ? (x * (1 << K)) : (a - (a >>> K) + x);
    e.ch = ch; e.y = use_c ? c_y : m_out(model[ch]); e.cyc = cyc;
    sb.push_back(e);
    @(posedge clk); #2;
    in_valid = 1'b0; bypass = 1'b0; clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic rst_pulse();
    idle(3);
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    model_clear();
  endtask

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  initial begin
    // hand-computed trajectory from reset (acc noted per record)
    tbl[0]  = '{0,  100, 1'b0, 1'b0, 0, 1};     // acc0=100
    tbl[1]  = '{0,  100, 1'b0, 1'b0, 0, 2};     // acc0=200
    tbl[2]  = '{1, -100, 1'b0, 1'b0, 0, -1};    // acc1=-100
    tbl[3]  = '{2,  -77, 1'b1, 1'b0, 0, -77};   // acc2=-9856
    tbl[4]  = '{0,  100, 1'b0, 1'b1, 0, 1};     // clear+sample: acc0=100
    tbl[5]  = '{3,   50, 1'b0, 1'b1, 0, 0};     // acc3=50, acc0 cleared
    tbl[6]  = '{0,  100, 1'b0, 1'b0, 0, 1};     // acc0=100 from 0
    tbl[7]  = '{2,  -77, 1'b0, 1'b0, 0, -77};   // acc2 stays -9856
    tbl[8]  = '{1, -100, 1'b0, 1'b0, 0, -2};    // acc1=-199
    tbl[9]  = '{2,  127, 1'b1, 1'b0, 0, 127};   // acc2=16256
    tbl[10] = '{2, -128, 1'b0, 1'b0, 0, 125};   // acc2=16001
    tbl[11] = '{3, -128, 1'b0, 1'b0, 0, -1};    // acc3=-78

    rst = 1'b1; in_valid = 1'b0; in_ch = '0; in_x = '0; bypass = 1'b0;
    clr = 1'b0; clr_ch = '0;
    d3_in_valid = 1'b0; d3_in_ch = '0; d3_in_x = '0; d3_bypass = 1'b0;
    d3_clr = 1'b0; d3_clr_ch = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #2;
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_ch", int'(out_ch), 0);
    check("reset_out_y", int'(out_y), 0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++)
      step(tbl[i].ch, tbl[i].x, tbl[i].byp, tbl[i].cl, tbl[i].cch, 1'b1, tbl[i].exp_y);

    // ch0 step to 100: ramps 1,2,... and settles exactly at 100
    rst_pulse();
    step(0, 100, 1'b0, 1'b0, 0, 1'b1, 1);
    step(0, 100, 1'b0, 1'b0, 0, 1'b1, 2);
    for (int i = 0; i < 1500; i++) step(0, 100, 1'b0, 1'b0, 0, 1'b0, 0);
    check("ch0_settled_acc_model", model[0], 12800);
    for (int i = 0; i < 5; i++) step(0, 100, 1'b0, 1'b0, 0, 1'b1, 100);

    // ch1 step to -100: first -1, settles at -99 (floor bias)
    step(1, -100, 1'b0, 1'b0, 0, 1'b1, -1);
    for (int i = 0; i < 1500; i++) step(1, -100, 1'b0, 1'b0, 0, 1'b0, 0);
    for (int i = 0; i < 5; i++) step(1, -100, 1'b0, 1'b0, 0, 1'b1, -99);

    // interleaved channels and same-channel bursts
    rst_pulse();
    for (int i = 0; i < 400; i++) begin
      case (i % 8)
        0, 2:    step(0,  127, 1'b0, 1'b0, 0, 1'b0, 0);
        1, 3:    step(2, -128, 1'b0, 1'b0, 0, 1'b0, 0);
        4, 5, 6: step(3,   50, 1'b0, 1'b0, 0, 1'b0, 0);
        default: step(0,  127, 1'b0, 1'b0, 0, 1'b0, 0);
      endcase
    end
    step(1, 0, 1'b0, 1'b0, 0, 1'b1, 0);

    // clears: same-channel clear with sample, then clear of another channel
    for (int i = 0; i < 1500; i++) step(0, 100, 1'b0, 1'b0, 0, 1'b0, 0);
    step(0, 100, 1'b0, 1'b0, 0, 1'b1, 100);
    step(0, 20, 1'b0, 1'b1, 0, 1'b1, 0);
    check("clr_same_ch_acc_model", model[0], 20);
    step(0, 100, 1'b0, 1'b1, 3, 1'b1, 1);
    step(3, 0, 1'b0, 1'b0, 0, 1'b1, 0);

    // bypass then smooth exit
    step(2, -77, 1'b1, 1'b0, 0, 1'b1, -77);
    for (int i = 0; i < 60; i++) step(2, -77, 1'b0, 1'b0, 0, 1'b1, -77);

    // reset with samples in flight
    idle(3);
    step(0, 100, 1'b0, 1'b0, 0, 1'b0, 0);
    step(1, 100, 1'b0, 1'b0, 0, 1'b0, 0);
    rst = 1'b1;
    @(posedge clk);
    sb.delete();
    #2;
    rst = 1'b0;
    model_clear();
    check("inflight_rst_out_valid", int'(out_valid), 0);
    check("inflight_rst_out_y", int'(out_y), 0);
    check("inflight_rst_out_ch", int'(out_ch), 0);
    idle(2);
    check("after_rst_no_output", int'(out_valid), 0);
    step(0, 100, 1'b0, 1'b0, 0, 1'b1, 1);
    step(1, -100, 1'b0, 1'b0, 0, 1'b1, -1);
    step(2, 100, 1'b0, 1'b0, 0, 1'b1, 1);

    // out-of-range channel on a 3-bit channel index build
    idle(3);
    d3_in_valid = 1'b1; d3_in_ch = 3'd5; d3_in_x = 8'sd100;
    @(posedge clk); #2;
    d3_in_valid = 1'b0;
    idle(4);
    check("ch5_no_output", d3_ys.size(), 0);
    d3_in_valid = 1'b1; d3_in_ch = 3'd0; d3_in_x = 8'sd100;
    @(posedge clk); #2;
    d3_clr = 1'b1; d3_clr_ch = 3'd6;
    @(posedge clk); #2;
    d3_in_valid = 1'b0; d3_clr = 1'b0;
    d3_in_ch = 3'd1; d3_in_valid = 1'b1;
    @(posedge clk); #2;
    d3_in_valid = 1'b0;
    idle(4);
    check("d3_output_count", d3_ys.size(), 3);
    if (d3_ys.size() == 3) begin
      check("d3_ch0_first", d3_ys[0], 1);
      check("d3_ch0_second_clr6_ignored", d3_ys[1], 2);
      check("d3_ch1_untouched", d3_ys[2], 1);
    end
    check("d3_last_ch", int'(d3_out_ch), 1);

    idle(4);
    check("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
